// File: rtl/sync_filt_pkg.sv
// Shared constants and helpers for the sync_filt_edge block.
//   SYNC_DEPTH_MIN : shallowest synchroniser chain the block will elaborate.
//   cnt_width()    : stability-counter width for a given filter length.
package sync_filt_pkg;

  localparam int unsigned SYNC_DEPTH_MIN = 2;

  // max(1, $clog2(filt_cycles)); the counter only needs to reach filt_cycles-1.
  function automatic int unsigned cnt_width(input int unsigned filt_cycles);
    int unsigned w;
    w = 32'd1;
    if (filt_cycles > 32'd2) w = 32'($clog2(filt_cycles));
    return w;
  endfunction

endpackage

// File: rtl/sync_filt_ch.sv
// One channel: flop synchroniser chain, stability counter, debounced level
// and registered rise/fall pulses.
//   clk_i    : destination clock
//   rst_i    : synchronous active-high reset
//   async_i  : asynchronous level input
//   filt_o   : synchronised, debounced level
//   rise_o   : one-cycle pulse on filt_o 0->1
//   fall_o   : one-cycle pulse on filt_o 1->0
//   edge_c_o : combinational, high when a pulse is loaded at the next edge
module sync_filt_ch
  import sync_filt_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH  = 2,
  parameter int unsigned FILT_CYCLES = 4,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_c_o
);

  localparam int unsigned          CNT_W   = cnt_width(FILT_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(FILT_CYCLES - 32'd1);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  sync_val;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  filt_q, filt_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;

  assign sync_val = sync_q[SYNC_DEPTH-1];

  // Plain shift chain; nothing between stages.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= {SYNC_DEPTH{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
  end

  // Any return to the current level clears the count, so only an unbroken
  // run of FILT_CYCLES differing samples moves the output.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_val == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      filt_d = sync_val;
      rise_d = sync_val;
      fall_d = ~sync_val;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt_o   = filt_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign edge_c_o = rise_d | fall_d;

endmodule

// File: rtl/sync_filt_edge.sv
// Multi-channel synchroniser with glitch filter and edge pulses.
//   clk_dst    : destination clock (only clock)
//   rst_dst    : synchronous active-high reset
//   async_in   : NUM_CH asynchronous level inputs
//   filt_out   : synchronised, debounced levels
//   rise_pulse : one-cycle pulse per channel on filt_out 0->1
//   fall_pulse : one-cycle pulse per channel on filt_out 1->0
//   change_any : registered OR of all pulses, same cycle as the pulses
// Optional (SYNC_FILT_EDGE_STICKY_EN defined):
//   sticky_clr : per-channel clear of sticky_evt
//   sticky_evt : per-channel latched "an edge occurred", set wins over clear
module sync_filt_edge
  import sync_filt_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       SYNC_DEPTH  = 2,
  parameter int unsigned       FILT_CYCLES = 4,
  parameter logic [NUM_CH-1:0] RST_VAL     = '0
) (
  input  logic              clk_dst,
  input  logic              rst_dst,
  input  logic [NUM_CH-1:0] async_in,
  output logic [NUM_CH-1:0] filt_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              change_any
`ifdef SYNC_FILT_EDGE_STICKY_EN
  ,
  input  logic [NUM_CH-1:0] sticky_clr,
  output logic [NUM_CH-1:0] sticky_evt
`endif
);

  if (SYNC_DEPTH < SYNC_DEPTH_MIN) begin : g_bad_depth
    $error("sync_filt_edge: SYNC_DEPTH must be at least 2");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("sync_filt_edge: FILT_CYCLES must be at least 1");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("sync_filt_edge: NUM_CH must be at least 1");
  end

  logic [NUM_CH-1:0] edge_c;
  logic              change_q, change_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sync_filt_ch #(
      .SYNC_DEPTH  (SYNC_DEPTH),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_VAL     (RST_VAL[i])
    ) u_ch (
      .clk_i    (clk_dst),
      .rst_i    (rst_dst),
      .async_i  (async_in[i]),
      .filt_o   (filt_out[i]),
      .rise_o   (rise_pulse[i]),
      .fall_o   (fall_pulse[i]),
      .edge_c_o (edge_c[i])
    );
  end

  // Built from next-state pulses so it lines up with the pulse registers.
  assign change_d = |edge_c;

  always_ff @(posedge clk_dst) begin
    if (rst_dst) change_q <= 1'b0;
    else         change_q <= change_d;
  end

  assign change_any = change_q;

`ifdef SYNC_FILT_EDGE_STICKY_EN
  logic [NUM_CH-1:0] sticky_q, sticky_d;

  // A pulse in the same cycle as a clear keeps the bit set.
  assign sticky_d = (rise_pulse | fall_pulse) | (sticky_q & ~sticky_clr);

  always_ff @(posedge clk_dst) begin
    if (rst_dst) sticky_q <= '0;
    else         sticky_q <= sticky_d;
  end

  assign sticky_evt = sticky_q;
`endif

endmodule

// File: tb/tb_sync_filt_edge.sv
// Scoreboard bench for sync_filt_edge (NUM_CH=4, SYNC_DEPTH=2, FILT_CYCLES=4,
// RST_VAL=4'b0101). Inputs change on negedges; outputs sampled on negedges.
module tb_sync_filt_edge;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  filt;
  } exp_t;

  logic       clk_dst = 1'b0;
  logic       rst_dst;
  logic [3:0] async_in;
  logic [3:0] filt_out, rise_pulse, fall_pulse;
  logic       change_any;
`ifdef SYNC_FILT_EDGE_STICKY_EN
  logic [3:0] sticky_clr;
  logic [3:0] sticky_evt;
`endif

  int unsigned cyc   = 0;
  int          total = 0;
  int          bad   = 0;
  exp_t        exp_q[$];
  bit          stim_done = 1'b0;

  always #5 clk_dst = ~clk_dst;
  always @(posedge clk_dst) cyc <= cyc + 1;

  sync_filt_edge #(
    .NUM_CH      (4),
    .SYNC_DEPTH  (2),
    .FILT_CYCLES (4),
    .RST_VAL     (4'b0101)
  ) dut (
    .clk_dst    (clk_dst),
    .rst_dst    (rst_dst),
    .async_in   (async_in),
    .filt_out   (filt_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .change_any (change_any)
`ifdef SYNC_FILT_EDGE_STICKY_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_evt (sticky_evt)
`endif
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) @(negedge clk_dst);
  endtask

  // Expected event dly cycles after the current negedge.
  task automatic expect_evt(input int unsigned dly, input logic [3:0] r,
                            input logic [3:0] f, input logic [3:0] fl);
    exp_t e;
    e.cyc  = cyc + dly;
    e.rise = r;
    e.fall = f;
    e.filt = fl;
    exp_q.push_back(e);
  endtask

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every change_any cycle must match the head of the queue.
  always @(negedge clk_dst) begin
    if (!stim_done) begin
      if (change_any === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: cyc %0d rise %b fall %b filt %b",
                   cyc, rise_pulse, fall_pulse, filt_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || rise_pulse !== e.rise || fall_pulse !== e.fall ||
              filt_out !== e.filt) begin
            bad++;
            $display("FAIL event: got cyc %0d rise %b fall %b filt %b expected cyc %0d rise %b fall %b filt %b",
                     cyc, rise_pulse, fall_pulse, filt_out, e.cyc, e.rise, e.fall, e.filt);
          end
        end
      end else begin
        total++;
        if ((rise_pulse | fall_pulse) !== 4'b0000) begin
          bad++;
          $display("FAIL pulse_without_change: cyc %0d rise %b fall %b", cyc, rise_pulse, fall_pulse);
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          bad++;
          $display("FAIL missing_event: expected at cyc %0d, not observed by cyc %0d",
                   exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_dst  = 1'b1;
    async_in = 4'b0101;
`ifdef SYNC_FILT_EDGE_STICKY_EN
    sticky_clr = 4'b0000;
`endif
    // Reset with inputs equal to RST_VAL; quiet for 20 cycles after release.
    tick(3);
    check4("reset_filt", filt_out, 4'b0101);
    check4("reset_rise", rise_pulse, 4'b0000);
    check4("reset_fall", fall_pulse, 4'b0000);
    check4("reset_change", {3'b000, change_any}, 4'b0000);
    rst_dst = 1'b0;
    tick(20);
    check4("idle_filt", filt_out, 4'b0101);

    // ch0 fall then rise, 6-cycle latency each.
    async_in = 4'b0100;
    expect_evt(6, 4'b0000, 4'b0001, 4'b0100);
    tick(10);
    async_in = 4'b0101;
    expect_evt(6, 4'b0001, 4'b0000, 4'b0101);
    tick(10);

    // ch2 brought low, then a 3-cycle glitch (rejected) and a 4-cycle pulse.
    async_in = 4'b0001;
    expect_evt(6, 4'b0000, 4'b0100, 4'b0001);
    tick(10);
    async_in = 4'b0101;
    tick(3);
    async_in = 4'b0001;
    tick(12);
    check4("glitch_filt", filt_out, 4'b0001);
    async_in = 4'b0101;
    expect_evt(6, 4'b0100, 4'b0000, 4'b0101);
    expect_evt(10, 4'b0000, 4'b0100, 4'b0001);
    tick(4);
    async_in = 4'b0001;
    tick(12);

    // All channels rise together.
    async_in = 4'b0000;
    expect_evt(6, 4'b0000, 4'b0001, 4'b0000);
    tick(10);
    async_in = 4'b1111;
    expect_evt(6, 4'b1111, 4'b0000, 4'b1111);
    tick(10);

    // Reset lands on the third counted cycle; count restarts after release.
    async_in = 4'b0000;
    tick(4);
    rst_dst = 1'b1;
    tick(1);
    rst_dst = 1'b0;
    check4("midreset_filt", filt_out, 4'b0101);
    check4("midreset_pulses", rise_pulse | fall_pulse, 4'b0000);
    expect_evt(6, 4'b0000, 4'b0101, 4'b0000);
    tick(5);
    check4("midreset_hold", filt_out, 4'b0101);
    tick(5);
    check4("midreset_final", filt_out, 4'b0000);

`ifdef SYNC_FILT_EDGE_STICKY_EN
    async_in = 4'b0010;
    expect_evt(6, 4'b0010, 4'b0000, 4'b0010);
    tick(10);
    sticky_clr = 4'b1111;
    tick(1);
    sticky_clr = 4'b0000;
    check4("sticky_cleared", sticky_evt, 4'b0000);
    async_in = 4'b0000;
    expect_evt(6, 4'b0000, 4'b0010, 4'b0000);
    tick(6);
    sticky_clr = 4'b0010;
    tick(1);
    check4("sticky_set_wins", sticky_evt, 4'b0010);
    tick(1);
    check4("sticky_clear", sticky_evt, 4'b0000);
    sticky_clr = 4'b0000;
    tick(4);
`endif

    tick(4);
    stim_done = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: %0d expected events never seen", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
